// File: rtl/irq_controller.sv
// Vectored interrupt controller: per-line synchroniser, edge/level pending, mask, fixed priority.
// Optional nesting (higher channel preempts the one in service) is enabled by IRQ_NESTING_EN.
module irq_controller #(
  parameter int unsigned N_IRQ       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ID_W        = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_async,
  input  logic [N_IRQ-1:0] irq_mode,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             irq_disable,
  input  logic             irq_ack,
  input  logic             irq_eoi,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] irq_pending,
  output logic             irq_active
);

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] sync_lvl;
  logic [N_IRQ-1:0] edge_det;

  logic [N_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [N_IRQ-1:0] in_service_q, in_service_d;
  logic             req_q, req_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic             ack_acc;
  logic [N_IRQ-1:0] ack_onehot;
  logic             is_any;
  logic [ID_W-1:0]  is_top;
  logic [N_IRQ-1:0] gate;
  logic [N_IRQ-1:0] eligible;
  logic             win_any;
  logic [ID_W-1:0]  win_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_lvl & ~prev_q;

  assign ack_acc = irq_ack & req_q;

  always_comb begin
    ack_onehot = '0;
    if (ack_acc) begin
      ack_onehot[id_q] = 1'b1;
    end
  end

  // A fresh edge wins over the ack clear of the same channel.
  assign edge_pend_d = irq_mode & (edge_det | (edge_pend_q & ~ack_onehot));

  // Level channels mirror the synchronised line; edge channels use the latched bit.
  assign irq_pending = (irq_mode & edge_pend_q) | (~irq_mode & sync_lvl);

  always_comb begin
    is_any = |in_service_q;
    is_top = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (in_service_q[i]) begin
        is_top = ID_W'(i);
      end
    end
  end

`ifdef IRQ_NESTING_EN
  always_comb begin
    gate = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      gate[i] = !is_any || (ID_W'(i) > is_top);
    end
  end
`else
  assign gate = is_any ? '0 : '1;
`endif

  assign eligible = irq_disable ? '0 : (irq_pending & ~irq_mask & gate);

  always_comb begin
    win_any = |eligible;
    win_idx = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (eligible[i]) begin
        win_idx = ID_W'(i);
      end
    end
  end

  // The eoi pops the pre-ack top of stack; the ack's bit is then pushed.
  always_comb begin
    in_service_d = in_service_q;
    if (irq_eoi && is_any) begin
      in_service_d[is_top] = 1'b0;
    end
    in_service_d = in_service_d | ack_onehot;
  end

  always_comb begin
    req_d = req_q;
    id_d  = id_q;
    if (ack_acc) begin
      req_d = 1'b0;
    end else begin
      req_d = win_any;
      if (win_any) begin
        id_d = win_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_pend_q  <= '0;
      in_service_q <= '0;
      req_q        <= 1'b0;
      id_q         <= '0;
    end else begin
      edge_pend_q  <= edge_pend_d;
      in_service_q <= in_service_d;
      req_q        <= req_d;
      id_q         <= id_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_id     = id_q;
  assign irq_active = |in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_irq_controller;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq_async = '0;
  logic [N-1:0]  irq_mode = '1;
  logic [N-1:0]  irq_mask = '0;
  logic          irq_disable = 1'b0;
  logic          irq_ack = 1'b0;
  logic          irq_eoi = 1'b0;
  logic          irq_req;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  irq_pending;
  logic          irq_active;

  always #5 clk = ~clk;

  irq_controller #(.N_IRQ(N), .SYNC_STAGES(S), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_async  (irq_async),
    .irq_mode   (irq_mode),
    .irq_mask   (irq_mask),
    .irq_disable(irq_disable),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_pending(irq_pending),
    .irq_active (irq_active)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Model: samp[k] is the line value sampled k edges ago (samp[0] newest).
  bit [N-1:0] samp [0:S];
  bit [N-1:0] m_epend;
  bit [N-1:0] m_is;
  bit         m_req;
  int         m_id;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int highest(input bit [N-1:0] v);
    int h = -1;
    for (int i = 0; i < N; i++) if (v[i]) h = i;
    return h;
  endfunction

  function automatic bit [N-1:0] m_pending();
    bit [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = irq_mode[i] ? m_epend[i] : samp[S-1][i];
    return p;
  endfunction

  function automatic bit gate_ok(input int i, input int top);
`ifdef IRQ_NESTING_EN
    return (top < 0) || (i > top);
`else
    return top < 0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= S; k++) samp[k] = '0;
    m_epend = '0;
    m_is    = '0;
    m_req   = 1'b0;
    m_id    = 0;
  endtask

  task automatic model_update();
    bit [N-1:0] pend;
    bit [N-1:0] elig;
    bit [N-1:0] edg;
    int top;
    int win;
    bit acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pend = m_pending();
    top  = highest(m_is);
    elig = '0;
    for (int i = 0; i < N; i++)
      if (pend[i] && !irq_mask[i] && !irq_disable && gate_ok(i, top)) elig[i] = 1'b1;
    win = highest(elig);
    acc = irq_ack && m_req;
    edg = samp[S-1] & ~samp[S];
    for (int i = 0; i < N; i++) begin
      if (!irq_mode[i]) m_epend[i] = 1'b0;
      else if (edg[i]) m_epend[i] = 1'b1;
      else if (acc && m_id == i) m_epend[i] = 1'b0;
    end
    if (irq_eoi && top >= 0) m_is[top] = 1'b0;
    if (acc) m_is[m_id] = 1'b1;
    if (acc) m_req = 1'b0;
    else begin
      m_req = (win >= 0);
      if (win >= 0) m_id = win;
    end
    for (int k = S; k > 0; k--) samp[k] = samp[k-1];
    samp[0] = irq_async;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("req", 32'(irq_req), 32'(m_req));
      cmp("id", 32'(irq_id), 32'(m_id));
      cmp("pending", 32'(irq_pending), 32'(m_pending()));
      cmp("active", 32'(irq_active), 32'(|m_is));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  task automatic pulse(input int ch);
    irq_async[ch] = 1'b1;
    step(1);
    irq_async[ch] = 1'b0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    irq_eoi = 1'b1;
    step(1);
    irq_eoi = 1'b0;
  endtask

  task automatic expect_zero(input string tag);
    cmp({tag, "_req"}, 32'(irq_req), 32'd0);
    cmp({tag, "_id"}, 32'(irq_id), 32'd0);
    cmp({tag, "_pending"}, 32'(irq_pending), 32'd0);
    cmp({tag, "_active"}, 32'(irq_active), 32'd0);
  endtask

  initial begin
    model_reset();
    step(3);
    expect_zero("reset");
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step(2);

    // Single edge on ch3: request after the fourth edge.
    pulse(3);
    step(3);
    cmp("ch3_req", 32'(irq_req), 32'd1);
    cmp("ch3_id", 32'(irq_id), 32'd3);
    cmp("ch3_pend", 32'(irq_pending), 32'h08);
    do_ack();
    cmp("ch3_ack_pend", 32'(irq_pending), 32'h00);
    cmp("ch3_ack_active", 32'(irq_active), 32'd1);
    cmp("ch3_ack_req", 32'(irq_req), 32'd0);
    step(1);
    do_eoi();
    cmp("ch3_eoi_active", 32'(irq_active), 32'd0);
    step(3);

    // Simultaneous edges on ch1 and ch6: highest index first.
    irq_async[1] = 1'b1;
    irq_async[6] = 1'b1;
    step(1);
    irq_async = '0;
    step(3);
    cmp("prio_id_first", 32'(irq_id), 32'd6);
    cmp("prio_req_first", 32'(irq_req), 32'd1);
    do_ack();
    cmp("prio_pend_after_ack", 32'(irq_pending), 32'h02);
    do_eoi();
    step(1);
    cmp("prio_req_second", 32'(irq_req), 32'd1);
    cmp("prio_id_second", 32'(irq_id), 32'd1);
    do_ack();
    do_eoi();
    step(3);

    // Level ch2 behind a mask, then unmasked, acked and re-requested.
    irq_mode[2] = 1'b0;
    irq_mask[2] = 1'b1;
    irq_async[2] = 1'b1;
    step(3);
    cmp("lvl_masked_pend", 32'(irq_pending), 32'h04);
    cmp("lvl_masked_req", 32'(irq_req), 32'd0);
    irq_mask[2] = 1'b0;
    step(1);
    cmp("lvl_unmask_req", 32'(irq_req), 32'd1);
    cmp("lvl_unmask_id", 32'(irq_id), 32'd2);
    do_ack();
    cmp("lvl_ack_pend", 32'(irq_pending), 32'h04);
    do_eoi();
    step(1);
    cmp("lvl_rereq", 32'(irq_req), 32'd1);
    irq_async[2] = 1'b0;
    step(4);
    cmp("lvl_drop_req", 32'(irq_req), 32'd0);
    irq_mode[2] = 1'b1;
    step(2);

    // Nesting: ch2 in service, then an edge on ch5.
    pulse(2);
    step(3);
    do_ack();
    pulse(5);
    step(3);
`ifdef IRQ_NESTING_EN
    cmp("nest_req", 32'(irq_req), 32'd1);
    cmp("nest_id", 32'(irq_id), 32'd5);
    do_ack();
    do_eoi();
    cmp("nest_eoi1_active", 32'(irq_active), 32'd1);
    do_eoi();
    cmp("nest_eoi2_active", 32'(irq_active), 32'd0);
`else
    cmp("nonest_req", 32'(irq_req), 32'd0);
    cmp("nonest_pend", 32'(irq_pending), 32'h20);
    do_eoi();
    step(1);
    cmp("nonest_req_after", 32'(irq_req), 32'd1);
    cmp("nonest_id_after", 32'(irq_id), 32'd5);
    do_ack();
    do_eoi();
`endif
    step(3);

    // Second ch4 edge lands on the ack edge: pending survives.
    irq_async[4] = 1'b1; step(1);
    irq_async[4] = 1'b0; step(1);
    irq_async[4] = 1'b1; step(1);
    irq_async[4] = 1'b0; step(1);
    cmp("ch4_req", 32'(irq_req), 32'd1);
    do_ack();
    cmp("ch4_pend_kept", 32'(irq_pending), 32'h10);
    cmp("ch4_gap_req", 32'(irq_req), 32'd0);
    step(1);
    do_eoi();
    step(1);
    cmp("ch4_rereq", 32'(irq_req), 32'd1);
    cmp("ch4_rereq_id", 32'(irq_id), 32'd4);
    do_ack();
    do_eoi();
    step(3);

    // Asynchronous reset with state in flight.
    pulse(1);
    step(3);
    do_ack();
    irq_mode[6] = 1'b0;
    irq_async[6] = 1'b1;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    expect_zero("async_rst");
    model_reset();
    irq_async = '0;
    irq_mode = '1;
    step(2);
    rst_n = 1'b1;
    step(2);

    // Randomized traffic, one mode pattern per segment.
    for (int seg = 0; seg < 4; seg++) begin
      rst_n = 1'b0;
      model_reset();
      irq_mode = N'($urandom);
      irq_mask = N'($urandom) & N'($urandom);
      irq_async = '0;
      step(2);
      rst_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 7) == 0) irq_async[i] = ~irq_async[i];
        if ($urandom_range(0, 31) == 0) irq_mask = N'($urandom) & N'($urandom);
        irq_disable = ($urandom_range(0, 15) == 0);
        irq_ack = ($urandom_range(0, 2) == 0);
        irq_eoi = ($urandom_range(0, 5) == 0);
        step(1);
      end
      irq_ack = 1'b0;
      irq_eoi = 1'b0;
      irq_disable = 1'b0;
    end

    step(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
# irq_controller

Parametrised vectored interrupt controller for the MIPS CPU. It takes `N_IRQ` asynchronous interrupt lines and, per channel, synchronises each line, detects an edge or tracks a level, and holds the request as pending. It applies a mask and a global disable, arbitrates by fixed priority (highest index wins), and presents one request with its vector ID to the core. A request/acknowledge/end-of-interrupt handshake maintains per-channel in-service state.

## Interface
Parameters:
- `N_IRQ`, 8: number of interrupt channels (2..32).
- `SYNC_STAGES`, 2: synchroniser flops per line (minimum 2).
- `ID_W`, `$clog2(N_IRQ)`: width of `irq_id`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `irq_async`  in  N_IRQ  raw interrupt lines, asynchronous to `clk`.
- `irq_mode`  in  N_IRQ  per channel: 1 = rising-edge triggered, 0 = level (active-high).
- `irq_mask`  in  N_IRQ  per channel: 1 = masked.
- `irq_disable`  in  1  global disable; blocks new requests and leaves pending state unchanged.
- `irq_ack`  in  1  core accepts the presented request.
- `irq_eoi`  in  1  single-cycle pulse: end of the current (highest) in-service interrupt.
- `irq_req`  out  1  request to the core (registered).
- `irq_id`  out  ID_W  index of the requesting channel (registered; valid while `irq_req`=1).
- `irq_pending`  out  N_IRQ  pending bits, for status reads.
- `irq_active`  out  1  OR of all in-service bits.

## Operation
- Synchroniser: each line passes through `SYNC_STAGES` flops. An additional flop `prev` holds the previous synchronised value. Edge detect = `sync & ~prev`.
- Pending, edge channel: set by a detected edge. Cleared on the edge where the ack is accepted for that channel. If a set and an ack clear occur in the same cycle, set wins.
- Pending, level channel: equals the synchronised level every cycle. An ack does not clear it; the source must deassert the line.
- Eligible = `pending & ~irq_mask & gate`, forced to 0 when `irq_disable`=1. `gate` is defined under Configuration.
- Arbitration: the highest eligible index wins. When eligible is non-zero, `irq_req` <= 1 and `irq_id` <= winner on the next edge.
- Ack accepted = `irq_ack & irq_req` sampled at an edge. On that edge:
  - `in_service[irq_id]` is set.
  - The pending bit of `irq_id` is cleared (edge mode only).
  - `irq_req` is forced to 0 for exactly one cycle, after which arbitration resumes.
- An ack sampled while `irq_req`=0 is ignored.
- The ack always applies to the `irq_id` currently registered, even if that channel's mask changed during the same cycle.
- `irq_eoi` clears the highest-index set in-service bit. An `irq_eoi` with no bit in service is ignored. An accepted ack and an `irq_eoi` on the same edge are both applied: the eoi clears the highest bit set before the ack, then the ack's bit is set.
- The in-service bit of a level channel blocks re-request of that channel until eoi.

## Timing
- Reset (async, `rst_n`=0): all sync and `prev` flops, pending, in_service, `irq_req`, and `irq_id` go to 0. Outputs read `irq_req`=0, `irq_id`=0, `irq_pending`=0, `irq_active`=0.
- Reset release in the middle of a transaction discards all pending and in-service state.
- Edge latency: a line that is high before edge 1 gives pending=1 after edge `SYNC_STAGES`+1 and `irq_req`=1 after edge `SYNC_STAGES`+2. With defaults, `irq_req` asserts after edge 4.
- Level latency: pending follows the line after edge `SYNC_STAGES`. `irq_req` follows one edge later.
- Mask, disable, and in-service changes take effect on `irq_req`/`irq_id` at the next edge.
- `irq_id` may change while `irq_req`=1 if a higher-priority channel becomes eligible. The core must ack only the `irq_id` it sampled in the same cycle.

## Configuration
- `IRQ_NESTING_EN` defined: `gate[i]` = 1 when i is greater than the highest set in-service index, or when no bit is in service. A higher-priority channel therefore preempts one already in service, and in_service acts as a nesting stack that eoi pops.
- `IRQ_NESTING_EN` undefined: `gate` = all ones only while `in_service`=0. No request is made while any interrupt is in service, so at most one in_service bit is ever set.

## Test plan
- N_IRQ=8, ch3 edge: pulse `irq_async[3]` high for 1 cycle (held across a sampling edge) -> `irq_req`=1 and `irq_id`=3 four edges later. Ack -> `irq_pending`[3]=0, `irq_active`=1, `irq_req`=0 for one cycle. Eoi -> `irq_active`=0.
- Edges on ch1 and ch6 in the same cycle -> `irq_id`=6 first. After ack and eoi -> `irq_id`=1.
- Ch2 level held high with mask[2]=1 -> `irq_req` stays 0 while `irq_pending`[2]=1. Clear the mask -> `irq_req`=1 with `irq_id`=2 on the next edge. Ack and eoi with the line still high -> re-requested.
- Nesting: ch2 in service, then an edge on ch5 -> with `IRQ_NESTING_EN`, `irq_req`=1 and `irq_id`=5, and eoi clears ch5 first. Without the macro -> no request until eoi.
- A second edge on ch4 lands on the same edge as the ack of ch4 -> `irq_pending`[4] stays 1, and the request reappears after eoi and the gap cycle.
- Assert `rst_n`=0 while `irq_req`=1 and a bit is in service -> all outputs read 0 immediately, without waiting for a clock edge.
